// File: rtl/flag_filt_pkg.sv
// Shared types and constants for the flag debounce / event-count path.
package flag_filt_pkg;

   typedef enum logic [1:0] {
      StLow,
      StRiseChk,
      StHigh,
      StFallChk
   } filt_state_e;

   localparam int unsigned SyncStagesDef = 2;
   localparam int unsigned StableCycDef  = 4;
   localparam int unsigned CntWDef       = 8;

   // All-ones value of a w-bit counter; 64-bit so w = 32 does not overflow.
   function automatic logic [63:0] SAT_MAX(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Plain flop-chain synchroniser for a single asynchronous bit, cleared by a synchronous reset.
module bit_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d};
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/flag_debounce_counter.sv
// Synchronises and debounces the glitchy hazard flag, then counts and hands off its rise events.
import flag_filt_pkg::*;

module flag_debounce_counter #(
   parameter int unsigned SYNC_STAGES = SyncStagesDef,
   parameter int unsigned STABLE_CYC  = StableCycDef,
   parameter int unsigned CNT_W       = CntWDef
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flag_in,
   output logic             flag_clean,
   output logic             rise_pulse,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] evt_count,
   output logic             evt_overflow,
   input  logic             cnt_clr
);

   localparam int unsigned      StabW   = $clog2(STABLE_CYC + 1);
   localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYC);
   localparam logic [StabW-1:0] StabOne = StabW'(1);
   localparam logic [CNT_W-1:0] CntMax  = CNT_W'(SAT_MAX(CNT_W));
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   logic             flag_s;
   filt_state_e      state_q;
   logic [StabW-1:0] stab_q;
   logic [StabW-1:0] stab_inc;

   bit_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (flag_in),
      .q  (flag_s)
   );

   assign stab_inc = stab_q + StabOne;

   // The edge that completes the stability window also updates flag_clean and rise_pulse,
   // so both outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StLow;
         stab_q     <= '0;
         flag_clean <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         case (state_q)
            StLow: begin
               if (flag_s) begin
                  if (STABLE_CYC == 1) begin
                     state_q    <= StHigh;
                     stab_q     <= '0;
                     flag_clean <= 1'b1;
                     rise_pulse <= 1'b1;
                  end else begin
                     state_q <= StRiseChk;
                     stab_q  <= StabOne;
                  end
               end
            end
            StRiseChk: begin
               if (!flag_s) begin
                  state_q <= StLow;
                  stab_q  <= '0;
               end else if (stab_inc == StabMax) begin
                  state_q    <= StHigh;
                  stab_q     <= '0;
                  flag_clean <= 1'b1;
                  rise_pulse <= 1'b1;
               end else begin
                  stab_q <= stab_inc;
               end
            end
            StHigh: begin
               if (!flag_s) begin
                  if (STABLE_CYC == 1) begin
                     state_q    <= StLow;
                     stab_q     <= '0;
                     flag_clean <= 1'b0;
                  end else begin
                     state_q <= StFallChk;
                     stab_q  <= StabOne;
                  end
               end
            end
            StFallChk: begin
               if (flag_s) begin
                  state_q <= StHigh;
                  stab_q  <= '0;
               end else if (stab_inc == StabMax) begin
                  state_q    <= StLow;
                  stab_q     <= '0;
                  flag_clean <= 1'b0;
               end else begin
                  stab_q <= stab_inc;
               end
            end
            default: begin
               state_q    <= StLow;
               stab_q     <= '0;
               flag_clean <= 1'b0;
            end
         endcase
      end
   end

   // A clear coincident with a rise keeps that rise, so the count restarts at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_count    <= '0;
         evt_overflow <= 1'b0;
      end else if (cnt_clr) begin
         evt_count    <= rise_pulse ? CntOne : '0;
         evt_overflow <= 1'b0;
      end else if (rise_pulse) begin
         if (evt_count == CntMax) begin
            evt_overflow <= 1'b1;
         end else begin
            evt_count <= evt_count + CntOne;
         end
      end
   end

   // Pending rises coalesce into one valid; a fresh rise outranks an acknowledge.
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_valid <= 1'b0;
      end else if (rise_pulse) begin
         evt_valid <= 1'b1;
      end else if (evt_valid && evt_ready) begin
         evt_valid <= 1'b0;
      end
   end

endmodule
